wb_merge: RTL and testbench

- Write-back merge stage: the retire-side counterpart of the issue scheduler.
- Collects completed results from the main pipeline and from COP_NUMS coprocessors, and serialises them onto the single integer register-file write port.
- Main results are never delayed. Coprocessor results queue in per-source FIFOs and drain in cycles when main is idle.
- Also exports a pending-register mask, so the scheduler can hold instructions that depend on queued coprocessor results.

---
 rtl/wb_pkg.sv | 12 +
 rtl/wb_fifo.sv | 70 +++++++
 rtl/wb_merge.sv | 138 +++++++++++++
 tb/tb_wb_merge.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back merge stage.
package wb_pkg;
  localparam int             WB_SRC_W    = 3;
  localparam logic [2:0]     WB_SRC_MAIN = 3'd0;
  localparam int             REG_ADDR_W  = 5;
  localparam int             XLEN        = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Single-clock result FIFO with flush and a per-slot valid view of queued destinations.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          i_flush,
  input  logic                          i_push,
  input  wb_entry_t                     i_push_entry,
  input  logic                          i_pop,
  output wb_entry_t                     o_head,
  output logic                          o_full,
  output logic                          o_empty,
  output logic [DEPTH-1:0]              o_entry_valid,
  output logic [DEPTH*REG_ADDR_W-1:0]   o_entry_rd
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t         r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_do_push;
  logic              w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push && !o_full && !i_flush;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_head    = r_mem[r_rd_ptr];

  // NOTE: storage has no reset; validity is tracked solely by the pointers and count.
  always_ff @(posedge CLK) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_entry;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
      else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    o_entry_valid = '0;
    for (int k = 0; k < DEPTH; k++) begin
      logic [PW-1:0] off;
      off = PW'(k) - r_rd_ptr;
      o_entry_valid[k] = ({1'b0, off} < r_count);
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_rd
    assign o_entry_rd[k*REG_ADDR_W +: REG_ADDR_W] = r_mem[k].rd;
  end
endmodule

// File: rtl/wb_merge.sv
// Write-back merge: main results take the port, coprocessor FIFOs drain when main is idle.
// Define WB_MERGE_RR_EN for round-robin coprocessor selection (default: fixed lowest index).
module wb_merge
  import wb_pkg::*;
#(
  parameter int COP_NUMS   = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    FLUSH,
  input  logic                    MAIN_VALID,
  input  logic [4:0]              MAIN_RD,
  input  logic [31:0]             MAIN_DATA,
  input  logic [COP_NUMS-1:0]     COP_VALID,
  input  logic [5*COP_NUMS-1:0]   COP_RD,
  input  logic [32*COP_NUMS-1:0]  COP_DATA,
  output logic [COP_NUMS-1:0]     COP_READY,
  output logic                    WB_VALID,
  output logic [4:0]              WB_RD,
  output logic [31:0]             WB_DATA,
  output logic [2:0]              WB_SRC,
  output logic [31:0]             PENDING_MASK,
  output logic                    BUSY
);
  logic [COP_NUMS-1:0]            w_push;
  logic [COP_NUMS-1:0]            w_pop;
  logic [COP_NUMS-1:0]            w_full;
  logic [COP_NUMS-1:0]            w_empty;
  wb_entry_t                      w_head [COP_NUMS];
  logic [FIFO_DEPTH-1:0]          w_ev   [COP_NUMS];
  logic [FIFO_DEPTH*5-1:0]        w_erd  [COP_NUMS];
  logic                           w_sel_valid;
  logic [WB_SRC_W-1:0]            w_sel;
  wb_entry_t                      w_sel_entry;
  logic [31:0]                    w_mask;

  logic                           r_wb_valid;
  logic [REG_ADDR_W-1:0]          r_wb_rd;
  logic [XLEN-1:0]                r_wb_data;
  logic [WB_SRC_W-1:0]            r_wb_src;

  for (genvar gi = 0; gi < COP_NUMS; gi++) begin : g_cop
    assign COP_READY[gi] = !w_full[gi];
    // rd==0 results complete the handshake but are never stored.
    assign w_push[gi]    = COP_VALID[gi] && COP_READY[gi] && (COP_RD[5*gi +: 5] != '0);

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .CLK           (CLK),
      .RST           (RST),
      .i_flush       (FLUSH),
      .i_push        (w_push[gi]),
      .i_push_entry  ('{rd: COP_RD[5*gi +: 5], data: COP_DATA[32*gi +: 32]}),
      .i_pop         (w_pop[gi]),
      .o_head        (w_head[gi]),
      .o_full        (w_full[gi]),
      .o_empty       (w_empty[gi]),
      .o_entry_valid (w_ev[gi]),
      .o_entry_rd    (w_erd[gi])
    );
  end

`ifdef WB_MERGE_RR_EN
  logic [WB_SRC_W-1:0] r_last;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                              r_last <= WB_SRC_W'(COP_NUMS - 1);
    else if (!MAIN_VALID && w_sel_valid)  r_last <= w_sel;
  end
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel       = '0;
    w_sel_entry = '0;
`ifdef WB_MERGE_RR_EN
    for (int k = 0; k < COP_NUMS; k++) begin
      for (int j = 0; j < COP_NUMS; j++) begin
        if (!w_sel_valid && j == (int'(r_last) + 1 + k) % COP_NUMS && !w_empty[j]) begin
          w_sel_valid = 1'b1;
          w_sel       = WB_SRC_W'(j);
          w_sel_entry = w_head[j];
        end
      end
    end
`else
    for (int j = 0; j < COP_NUMS; j++) begin
      if (!w_sel_valid && !w_empty[j]) begin
        w_sel_valid = 1'b1;
        w_sel       = WB_SRC_W'(j);
        w_sel_entry = w_head[j];
      end
    end
`endif
    w_pop = '0;
    for (int j = 0; j < COP_NUMS; j++)
      w_pop[j] = !MAIN_VALID && w_sel_valid && (w_sel == WB_SRC_W'(j));
  end

  // Any main result, even to x0, owns the write slot for that cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wb_valid <= 1'b0;
      r_wb_rd    <= '0;
      r_wb_data  <= '0;
      r_wb_src   <= WB_SRC_MAIN;
    end else if (MAIN_VALID) begin
      r_wb_valid <= (MAIN_RD != '0);
      if (MAIN_RD != '0) begin
        r_wb_rd   <= MAIN_RD;
        r_wb_data <= MAIN_DATA;
        r_wb_src  <= WB_SRC_MAIN;
      end
    end else if (w_sel_valid) begin
      r_wb_valid <= 1'b1;
      r_wb_rd    <= w_sel_entry.rd;
      r_wb_data  <= w_sel_entry.data;
      r_wb_src   <= w_sel + 3'd1;
    end else begin
      r_wb_valid <= 1'b0;
    end
  end

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < COP_NUMS; i++)
      for (int k = 0; k < FIFO_DEPTH; k++)
        if (w_ev[i][k]) w_mask[w_erd[i][k*5 +: 5]] = 1'b1;
  end

  assign PENDING_MASK = {w_mask[31:1], 1'b0};
  assign BUSY         = ~&w_empty;
  assign WB_VALID     = r_wb_valid;
  assign WB_RD        = r_wb_rd;
  assign WB_DATA      = r_wb_data;
  assign WB_SRC       = r_wb_src;
endmodule

// File: tb/tb_wb_merge.sv
// Directed bench for wb_merge with two coprocessor sources; expectations follow WB_MERGE_RR_EN.
module tb_wb_merge;
  localparam int N = 2;

  logic          CLK = 1'b0;
  logic          RST;
  logic          FLUSH;
  logic          MAIN_VALID;
  logic [4:0]    MAIN_RD;
  logic [31:0]   MAIN_DATA;
  logic [N-1:0]  COP_VALID;
  logic [5*N-1:0]  COP_RD;
  logic [32*N-1:0] COP_DATA;
  logic [N-1:0]  COP_READY;
  logic          WB_VALID;
  logic [4:0]    WB_RD;
  logic [31:0]   WB_DATA;
  logic [2:0]    WB_SRC;
  logic [31:0]   PENDING_MASK;
  logic          BUSY;

  int n_pass   = 0;
  int n_checks = 0;

  wb_merge #(.COP_NUMS(N), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
    .MAIN_VALID(MAIN_VALID), .MAIN_RD(MAIN_RD), .MAIN_DATA(MAIN_DATA),
    .COP_VALID(COP_VALID), .COP_RD(COP_RD), .COP_DATA(COP_DATA),
    .COP_READY(COP_READY),
    .WB_VALID(WB_VALID), .WB_RD(WB_RD), .WB_DATA(WB_DATA), .WB_SRC(WB_SRC),
    .PENDING_MASK(PENDING_MASK), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    FLUSH = 1'b0; MAIN_VALID = 1'b0; MAIN_RD = '0; MAIN_DATA = '0;
    COP_VALID = '0; COP_RD = '0; COP_DATA = '0;
  endtask

  task automatic main_in(input logic v, input logic [4:0] rd, input logic [31:0] d);
    MAIN_VALID = v; MAIN_RD = rd; MAIN_DATA = d;
  endtask

  task automatic cop_in(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
    COP_VALID[i] = v; COP_RD[5*i +: 5] = rd; COP_DATA[32*i +: 32] = d;
  endtask

  logic [2:0] exp_src [4];
  logic [4:0] exp_rd  [4];

  initial begin
    idle_inputs();
    RST = 1'b1;
    #12 RST = 1'b0;

    // Reset state
    check("rst_valid", WB_VALID, 0);
    check("rst_rd", WB_RD, 0);
    check("rst_data", WB_DATA, 0);
    check("rst_src", WB_SRC, 0);
    check("rst_ready", COP_READY, 2'b11);
    check("rst_pend", PENDING_MASK, 0);
    check("rst_busy", BUSY, 0);

    // Main only
    step();
    main_in(1, 5'd5, 32'hDEADBEEF);
    step();
    check("main_valid", WB_VALID, 1);
    check("main_rd", WB_RD, 5);
    check("main_data", WB_DATA, 32'hDEADBEEF);
    check("main_src", WB_SRC, 0);
    idle_inputs();
    step();
    check("idle_valid", WB_VALID, 0);
    check("idle_rd_hold", WB_RD, 5);

    // Main blocks coprocessor
    main_in(1, 5'd1, 32'h1);
    cop_in(0, 1, 5'd7, 32'h11);
    step();
    cop_in(0, 0, 5'd0, 32'h0);
    check("blk_pend0", PENDING_MASK[7], 1);
    check("blk_busy", BUSY, 1);
    main_in(1, 5'd2, 32'h2);
    step();
    check("blk_pend1", PENDING_MASK[7], 1);
    check("blk_main_rd", WB_RD, 2);
    main_in(1, 5'd3, 32'h3);
    step();
    check("blk_pend2", PENDING_MASK[7], 1);
    check("blk_main_src", WB_SRC, 0);
    idle_inputs();
    step();
    check("blk_cop_valid", WB_VALID, 1);
    check("blk_cop_rd", WB_RD, 7);
    check("blk_cop_data", WB_DATA, 32'h11);
    check("blk_cop_src", WB_SRC, 1);
    check("blk_pend_clr", PENDING_MASK, 0);
    step();
    check("blk_after", WB_VALID, 0);

    // Fill to full, 5th push ignored, drain in order
    main_in(1, 5'd1, 32'h1);
    for (int k = 0; k < 4; k++) begin
      cop_in(0, 1, 5'(10 + k), 32'(100 + k));
      step();
    end
    check("full_ready", COP_READY, 2'b10);
    check("full_pend", PENDING_MASK, 32'h0000_3C00);
    cop_in(0, 1, 5'd20, 32'd999);
    step();
    check("full_ready2", COP_READY, 2'b10);
    check("full_pend2", PENDING_MASK, 32'h0000_3C00);
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      step();
      check("drain_valid", WB_VALID, 1);
      check("drain_rd", WB_RD, 32'(10 + k));
      check("drain_data", WB_DATA, 32'(100 + k));
      check("drain_src", WB_SRC, 1);
    end
    check("drain_busy", BUSY, 0);

    // x0 filter
    main_in(1, 5'd0, 32'hAAAA);
    cop_in(0, 1, 5'd0, 32'h5);
    step();
    check("x0_valid", WB_VALID, 0);
    check("x0_rd_hold", WB_RD, 13);
    check("x0_ready", COP_READY, 2'b11);
    check("x0_busy", BUSY, 0);
    main_in(0, 5'd0, 32'h0);
    step();
    check("x0_valid2", WB_VALID, 0);
    check("x0_busy2", BUSY, 0);
    idle_inputs();

    // FLUSH with simultaneous main result
    main_in(1, 5'd1, 32'h1);
    cop_in(0, 1, 5'd3, 32'h33);
    step();
    cop_in(0, 1, 5'd4, 32'h44);
    step();
    check("fl_pend_pre", PENDING_MASK, 32'h18);
    FLUSH = 1'b1;
    main_in(1, 5'd9, 32'h99);
    cop_in(0, 1, 5'd5, 32'h55);
    step();
    idle_inputs();
    check("fl_valid", WB_VALID, 1);
    check("fl_rd", WB_RD, 9);
    check("fl_data", WB_DATA, 32'h99);
    check("fl_src", WB_SRC, 0);
    check("fl_pend", PENDING_MASK, 0);
    check("fl_busy", BUSY, 0);
    step();
    check("fl_after", WB_VALID, 0);

    // Asynchronous reset with queued entries and a write in flight
    main_in(1, 5'd1, 32'h1);
    cop_in(0, 1, 5'd15, 32'hF);
    cop_in(1, 1, 5'd16, 32'h10);
    step();
    check("ar_busy_pre", BUSY, 1);
    check("ar_valid_pre", WB_VALID, 1);
    RST = 1'b1;
    #1;
    check("ar_valid", WB_VALID, 0);
    check("ar_busy", BUSY, 0);
    check("ar_pend", PENDING_MASK, 0);
    check("ar_ready", COP_READY, 2'b11);
    idle_inputs();
    #1 RST = 1'b0;

    // Two sources, two entries each: arbitration order
`ifdef WB_MERGE_RR_EN
    exp_src = '{3'd1, 3'd2, 3'd1, 3'd2};
    exp_rd  = '{5'd11, 5'd21, 5'd12, 5'd22};
`else
    exp_src = '{3'd1, 3'd1, 3'd2, 3'd2};
    exp_rd  = '{5'd11, 5'd12, 5'd21, 5'd22};
`endif
    main_in(1, 5'd1, 32'h1);
    cop_in(0, 1, 5'd11, 32'hB1);
    cop_in(1, 1, 5'd21, 32'hC1);
    step();
    cop_in(0, 1, 5'd12, 32'hB2);
    cop_in(1, 1, 5'd22, 32'hC2);
    step();
    idle_inputs();
    check("arb_pend", PENDING_MASK, 32'h0060_1800);
    for (int k = 0; k < 4; k++) begin
      step();
      check("arb_valid", WB_VALID, 1);
      check("arb_src", WB_SRC, exp_src[k]);
      check("arb_rd", WB_RD, exp_rd[k]);
    end
    check("arb_busy", BUSY, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
